instr_fetch: RTL and testbench

//   Instruction-supply end of the decoder fetch handshake. Holds a loadable program RAM and a PC.

---
 rtl/rv_core_pkg.sv | 15 +
 rtl/instr_ram_sp.sv | 26 ++
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared core types: instruction width and fetch-side FSM encoding.
// Imported by the fetch unit and its program RAM.
package rv_core_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    READ    = 3'd2,
    PRESENT = 3'd3,
    FINISH  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instr_ram_sp.sv
// Single-port program RAM, synchronous read, not reset.
// One shared address; the owner never writes and reads in the same cycle.
module instr_ram_sp
  import rv_core_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [AW-1:0]      addr,
  input  logic [INSTR_W-1:0] wdata,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (int'(addr) < DEPTH))
      mem[addr] <= wdata;
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-supply side of the decoder handshake: program RAM,
// PC, delivery counter and a one-word-per-request fetch FSM.
module instr_fetch
  import rv_core_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic [AW:0]        prog_len,
  input  logic               start,
  input  logic               next_instr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done,
  output logic [AW:0]        fetch_cnt
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  fetch_state_e state, state_nx;

  logic [AW:0]        len_q;
  logic [AW:0]        len_clamp;
  logic [AW:0]        cnt_inc;
  logic               ram_we;
  logic               ram_re;
  logic [AW-1:0]      ram_addr;
  logic [INSTR_W-1:0] ram_rdata;

  assign len_clamp = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
  assign cnt_inc   = fetch_cnt + ONE_W;

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  // Reads are issued every WAIT cycle so the word is ready
  // in READ; writes only land while idle.
  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = pc;
    unique case (1'b1)
      (state == IDLE): begin
        ram_we   = prog_we;
        ram_addr = prog_addr;
      end
      (state == WAIT): ram_re = 1'b1;
      default: ;
    endcase
  end

  instr_ram_sp #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (prog_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (len_clamp == '0) ? FINISH : WAIT;
      end
      WAIT: begin
        if (next_instr)
          state_nx = READ;
      end
      READ:    state_nx = PRESENT;
      PRESENT: state_nx = (cnt_inc == len_q) ? FINISH : WAIT;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // instr_valid comes only from state, never from next_instr.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      fetch_cnt   <= '0;
      len_q       <= '0;
    end else begin
      state       <= state_nx;
      instr_valid <= (state == READ);
      if (state == READ)
        instr <= ram_rdata;
      if ((state == IDLE) && start) begin
        len_q     <= len_clamp;
        pc        <= '0;
        fetch_cnt <= '0;
      end
      if (state == PRESENT) begin
        pc        <= pc + 1'b1;
        fetch_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: hand-computed words, pulses,
// pc/count values and handshake timing.
module tb_instr_fetch;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_wdata;
  logic [AW:0]   prog_len;
  logic          start;
  logic          next_instr;
  logic [31:0]   instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic [AW:0]   fetch_cnt;

  int checks = 0;
  int passed = 0;

  logic [31:0] words[$];
  int          pcs[$];
  int          done_cnt = 0;
  logic        prev_v = 1'b0;

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .prog_len    (prog_len),
    .start       (start),
    .next_instr  (next_instr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prev_v) pcs.push_back(int'(pc));
    if (instr_valid) words.push_back(instr);
    if (done) done_cnt++;
    prev_v = instr_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clr();
    words.delete();
    pcs.delete();
    done_cnt = 0;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    prog_we    = 1'b1;
    prog_addr  = AW'(a);
    prog_wdata = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic go(input int len);
    prog_len = (AW+1)'(len);
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    int hold;
    reset_n    = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    prog_len   = '0;
    start      = 1'b0;
    next_instr = 1'b0;
    tick();
    tick();
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(fetch_cnt), 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: three words, request held high
    load(0, 32'h00500093);
    load(1, 32'h002081B3);
    load(2, 32'h00000013);
    clr();
    next_instr = 1'b1;
    go(3);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done_seen", 40);
    next_instr = 1'b0;
    chk("t1_npulse", 32'(words.size()), 32'd3);
    chk("t1_w0", words[0], 32'h00500093);
    chk("t1_w1", words[1], 32'h002081B3);
    chk("t1_w2", words[2], 32'h00000013);
    chk("t1_pc0", 32'(pcs[0]), 32'd1);
    chk("t1_pc1", 32'(pcs[1]), 32'd2);
    chk("t1_pc2", 32'(pcs[2]), 32'd3);
    chk("t1_pc", 32'(pc), 32'd3);
    chk("t1_cnt", 32'(fetch_cnt), 32'd3);
    chk("t1_ndone", 32'(done_cnt), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_hold", instr, 32'h00000013);

    // 2: idle decoder, then single request latency
    clr();
    go(3);
    repeat (10) tick();
    chk("t2_quiet", 32'(words.size()), 32'd0);
    next_instr = 1'b1;
    tick();
    next_instr = 1'b0;
    chk("t2_n1", 32'(instr_valid), 32'd0);
    tick();
    chk("t2_n2", 32'(instr_valid), 32'd1);
    chk("t2_word", instr, 32'h00500093);
    tick();
    chk("t2_n3", 32'(instr_valid), 32'd0);
    repeat (4) tick();
    chk("t2_single", 32'(words.size()), 32'd1);
    next_instr = 1'b1;
    wait_done("t2_done_seen", 40);
    next_instr = 1'b0;
    chk("t2_npulse", 32'(words.size()), 32'd3);

    // 3: decoder model, undefined word at addr 1
    load(1, 32'h00000000);
    clr();
    go(3);
    hold = 0;
    next_instr = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      if (instr_valid) hold = 3;
      next_instr = (hold == 0);
      if (hold > 0) hold--;
    end
    next_instr = 1'b0;
    chk("t3_done", 32'(done), 32'd1);
    tick();
    chk("t3_npulse", 32'(words.size()), 32'd3);
    chk("t3_w0", words[0], 32'h00500093);
    chk("t3_w1", words[1], 32'h00000000);
    chk("t3_w2", words[2], 32'h00000013);
    chk("t3_ndone", 32'(done_cnt), 32'd1);

    // 4a: zero length
    clr();
    go(0);
    wait_done("t4a_done_seen", 4);
    chk("t4a_nvalid", 32'(words.size()), 32'd0);
    chk("t4a_ndone", 32'(done_cnt), 32'd1);
    chk("t4a_busy", 32'(busy), 32'd0);

    // 4b: over-long length clamps to DEPTH
    clr();
    next_instr = 1'b1;
    go(DEPTH + 5);
    wait_done("t4b_done_seen", 400);
    next_instr = 1'b0;
    chk("t4b_npulse", 32'(words.size()), 32'(DEPTH));
    chk("t4b_cnt", 32'(fetch_cnt), 32'(DEPTH));
    chk("t4b_pc", 32'(pc), 32'd0);
    chk("t4b_w2", words[2], 32'h00000013);

    // 5: write and start while busy are ignored
    clr();
    go(3);
    prog_we    = 1'b1;
    prog_addr  = '0;
    prog_wdata = 32'hFFFFFFFF;
    prog_len   = '0;
    start      = 1'b1;
    repeat (3) tick();
    prog_we = 1'b0;
    start   = 1'b0;
    next_instr = 1'b1;
    wait_done("t5_done_seen", 40);
    next_instr = 1'b0;
    chk("t5_npulse", 32'(words.size()), 32'd3);
    chk("t5_w0", words[0], 32'h00500093);
    clr();
    next_instr = 1'b1;
    go(1);
    wait_done("t5_rerun_done", 20);
    next_instr = 1'b0;
    chk("t5_rerun_w0", words[0], 32'h00500093);

    // 6: reset during PRESENT
    clr();
    next_instr = 1'b1;
    go(3);
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    chk("t6_in_present", 32'(instr_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n    = 1'b1;
    next_instr = 1'b0;
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_instr", instr, 32'h0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_pc", 32'(pc), 32'd0);
    repeat (5) tick();
    chk("t6_ndone", 32'(done_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
